// File: rtl/hub75_pkg.sv
// Shared definitions for the HUB75 framebuffer write path.
//   CMD_*        header command codes
//   HDR_*_MSB    header field positions (each field is one byte)
//   state_t      SPI frame loader parse states
package hub75_pkg;
  localparam logic [7:0] CMD_WRITE = 8'h01;
  localparam logic [7:0] CMD_SWAP  = 8'h02;

  localparam int HDR_CMD_MSB = 31;
  localparam int HDR_ROW_MSB = 23;
  localparam int HDR_COL_MSB = 15;

  typedef enum logic [1:0] {
    HEADER = 2'd0,
    PIXELS = 2'd1,
    IGNORE = 2'd2
  } state_t;
endpackage

// File: rtl/hub75_pixel_pack.sv
// Truncates a 32-bit word of four byte lanes into one packed pixel.
//   word   in   32               byte lanes, lane 3 in [31:24]
//   pixel  out  BITS_PER_PIXEL   top R bits of each lane, lane 3 most significant
module hub75_pixel_pack #(
  parameter int BITS_PER_PIXEL = 16
) (
  input  logic [31:0]               word,
  output logic [BITS_PER_PIXEL-1:0] pixel
);
  localparam int R = BITS_PER_PIXEL / 4;

  for (genvar lane = 0; lane < 4; lane++) begin : g_lane
    assign pixel[(lane+1)*R-1 -: R] = word[lane*8+7 -: R];
  end
endmodule

// File: rtl/spi_frame_loader.sv
// SPI-side framebuffer write controller for the HUB75 panel driver.
// Each transaction (reset low) is a header word then pixel words, MSB first.
//   spi_clk      in   SPI clock, rising edge
//   reset        in   async active-high (chip select deasserted)
//   spi_mosi     in   serial data
//   fb_wr_en     out  write strobe, RAM captures on the same spi_clk edge
//   fb_wr_addr   out  {back_buf, row, col}
//   fb_wr_data   out  packed pixel
//   display_buf  out  buffer currently shown (survives transactions)
//   busy         out  high while a transaction is past its header
module spi_frame_loader
  import hub75_pkg::*;
#(
  parameter int BITS_PER_PIXEL = 16,
  parameter int WIDTH          = 64,
  parameter int HEIGHT         = 32
) (
  input  logic                                   spi_clk,
  input  logic                                   reset,
  input  logic                                   spi_mosi,
  output logic                                   fb_wr_en,
  output logic [$clog2(HEIGHT)+$clog2(WIDTH):0]  fb_wr_addr,
  output logic [BITS_PER_PIXEL-1:0]              fb_wr_data,
  output logic                                   display_buf,
  output logic                                   busy
);
  localparam int COL_BITS = $clog2(WIDTH);
  localparam int ROW_BITS = $clog2(HEIGHT);

  state_t              state;
  logic [4:0]          bit_cnt;
  logic [31:0]         shift;
  logic [ROW_BITS-1:0] row;
  logic [COL_BITS-1:0] col;

  // The displayed buffer must persist across transactions, so it is kept out
  // of the chip-select reset and relies on its power-up value instead.
  logic                display_buf_q = 1'b0;

  logic                word_done;
  logic [31:0]         word;
  logic [7:0]          hdr_cmd, hdr_row, hdr_col;
  logic                hdr_in_range;

  assign word_done = (bit_cnt == 5'd0);
  assign word      = {shift[30:0], spi_mosi};
  assign hdr_cmd   = word[HDR_CMD_MSB -: 8];
  assign hdr_row   = word[HDR_ROW_MSB -: 8];
  assign hdr_col   = word[HDR_COL_MSB -: 8];
  assign hdr_in_range = (int'(hdr_row) < HEIGHT) && (int'(hdr_col) < WIDTH);

  // Zero-latency strobe: the last bit is still on mosi, the RAM writes the
  // assembled word on the same edge that completes it.
  assign fb_wr_en    = (state == PIXELS) && word_done;
  assign fb_wr_addr  = {~display_buf_q, row, col};
  assign display_buf = display_buf_q;

  hub75_pixel_pack #(.BITS_PER_PIXEL(BITS_PER_PIXEL)) u_pack (
    .word  (word),
    .pixel (fb_wr_data)
  );

  always_ff @(posedge spi_clk or posedge reset) begin
    if (reset) begin
      state   <= HEADER;
      bit_cnt <= 5'd31;
      shift   <= '0;
      busy    <= 1'b0;
      row     <= '0;
      col     <= '0;
    end else begin
      shift   <= word;
      bit_cnt <= bit_cnt - 5'd1;
      if (word_done) begin
        case (state)
          HEADER: begin
            if (hdr_cmd == CMD_WRITE && hdr_in_range) begin
              row   <= hdr_row[ROW_BITS-1:0];
              col   <= hdr_col[COL_BITS-1:0];
              busy  <= 1'b1;
              state <= PIXELS;
            end else begin
              state <= IGNORE;
            end
          end
          PIXELS: begin
            if (col == COL_BITS'(WIDTH - 1)) begin
              col <= '0;
              row <= (row == ROW_BITS'(HEIGHT - 1)) ? '0 : row + 1'b1;
            end else begin
              col <= col + 1'b1;
            end
          end
          default: state <= IGNORE;
        endcase
      end
    end
  end

  // Bit counter sits at 31 while in reset, so no toggle can fire then.
  always_ff @(posedge spi_clk) begin
    if (state == HEADER && word_done && hdr_cmd == CMD_SWAP)
      display_buf_q <= ~display_buf_q;
  end
endmodule

// File: tb/tb_spi_frame_loader.sv
module tb_spi_frame_loader;
  logic        spi_clk = 1'b0;
  logic        clk_en  = 1'b0;
  logic        reset   = 1'b1;
  logic        spi_mosi = 1'b0;
  logic        fb_wr_en;
  logic [11:0] fb_wr_addr;
  logic [15:0] fb_wr_data;
  logic        display_buf;
  logic        busy;

  int checks = 0;
  int errs   = 0;

  spi_frame_loader dut (
    .spi_clk     (spi_clk),
    .reset       (reset),
    .spi_mosi    (spi_mosi),
    .fb_wr_en    (fb_wr_en),
    .fb_wr_addr  (fb_wr_addr),
    .fb_wr_data  (fb_wr_data),
    .display_buf (display_buf),
    .busy        (busy)
  );

  always begin
    #5;
    if (clk_en) spi_clk = ~spi_clk;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errs++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // Pulse CS between edges; the following negedge drives the first bit.
  task automatic start_txn();
    @(posedge spi_clk);
    #1 reset = 1'b1;
    #1 reset = 1'b0;
  endtask

  // Shift nbits of w MSB first. The strobe is checked on every bit; on the
  // 32nd bit it must equal exp_wr, and when set the address/data must match.
  task automatic send_word(input string tag, input logic [31:0] w, input int nbits,
                           input logic exp_wr, input logic [11:0] exp_addr,
                           input logic [15:0] exp_data);
    for (int i = 31; i > 31 - nbits; i--) begin
      @(negedge spi_clk);
      spi_mosi = w[i];
      #1;
      if (i == 0) begin
        chk({tag, ".wr_en"}, 32'(fb_wr_en), 32'(exp_wr));
        if (exp_wr) begin
          chk({tag, ".addr"}, 32'(fb_wr_addr), 32'(exp_addr));
          chk({tag, ".data"}, 32'(fb_wr_data), 32'(exp_data));
        end
      end else begin
        chk({tag, ".no_wr"}, 32'(fb_wr_en), 32'd0);
      end
    end
  endtask

  task automatic after_edge();
    @(posedge spi_clk);
    #1;
  endtask

  initial begin
    // 1. Power-up: reset pulse, clock idle
    #3 reset = 1'b0;
    #2;
    chk("pwr.wr_en", 32'(fb_wr_en), 32'd0);
    chk("pwr.busy", 32'(busy), 32'd0);
    chk("pwr.disp", 32'(display_buf), 32'd0);
    clk_en = 1'b1;

    // 2. Write two pixels at row 3, col 5
    start_txn();
    send_word("w2.hdr", 32'h01030500, 32, 1'b0, '0, '0);
    after_edge();
    chk("w2.busy", 32'(busy), 32'd1);
    send_word("w2.px0", 32'hF0E0D0C0, 32, 1'b1, {1'b1, 5'd3, 6'd5}, 16'hFEDC);
    send_word("w2.px1", 32'h12345678, 32, 1'b1, {1'b1, 5'd3, 6'd6}, 16'h1357);

    // 3. Wrap from last pixel of the panel back to origin
    start_txn();
    chk("w3.busy_rst", 32'(busy), 32'd0);
    send_word("w3.hdr", 32'h011F3F00, 32, 1'b0, '0, '0);
    send_word("w3.px0", 32'hAABBCCDD, 32, 1'b1, {1'b1, 5'd31, 6'd63}, 16'hABCD);
    send_word("w3.px1", 32'h11223344, 32, 1'b1, {1'b1, 5'd0, 6'd0}, 16'h1234);

    // 4. Swap, then write lands in the now-hidden buffer 0
    start_txn();
    send_word("w4.swap", 32'h02000000, 32, 1'b0, '0, '0);
    chk("w4.disp_before", 32'(display_buf), 32'd0);
    after_edge();
    chk("w4.disp_after", 32'(display_buf), 32'd1);
    chk("w4.busy", 32'(busy), 32'd0);
    start_txn();
    chk("w4.disp_keep", 32'(display_buf), 32'd1);
    send_word("w4.hdr", 32'h01000000, 32, 1'b0, '0, '0);
    send_word("w4.px0", 32'h9080A0B0, 32, 1'b1, {1'b0, 5'd0, 6'd0}, 16'h98AB);

    // 5. Abort mid-pixel, then a fresh header starts clean
    start_txn();
    send_word("w5.hdr", 32'h01101000, 32, 1'b0, '0, '0);
    send_word("w5.part", 32'hFFFFFFFF, 20, 1'b0, '0, '0);
    start_txn();
    chk("w5.busy_rst", 32'(busy), 32'd0);
    send_word("w5.hdr2", 32'h01020700, 32, 1'b0, '0, '0);
    send_word("w5.px0", 32'hCAFEBABE, 32, 1'b1, {1'b0, 5'd2, 6'd7}, 16'hCFBB);

    // Reset mid-header: no command effect
    start_txn();
    send_word("w5.hpart", 32'h02000000, 16, 1'b0, '0, '0);
    start_txn();
    chk("w5.hpart_disp", 32'(display_buf), 32'd1);

    // 6. Illegal command and out-of-range write
    start_txn();
    send_word("w6.hdr7f", 32'h7F000000, 32, 1'b0, '0, '0);
    send_word("w6.a", 32'h01020304, 32, 1'b0, '0, '0);
    send_word("w6.b", 32'h02000000, 32, 1'b0, '0, '0);
    send_word("w6.c", 32'hFFFFFFFF, 32, 1'b0, '0, '0);
    after_edge();
    chk("w6.disp", 32'(display_buf), 32'd1);
    chk("w6.busy", 32'(busy), 32'd0);
    start_txn();
    send_word("w6.row32", 32'h01200000, 32, 1'b0, '0, '0);
    after_edge();
    chk("w6.row32_busy", 32'(busy), 32'd0);
    send_word("w6.row32_px", 32'h12345678, 32, 1'b0, '0, '0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", checks, errs);
    $finish;
  end
endmodule
